// File: rtl/seq_counter_ctrl.sv
// Sequence-counter controller: run flip-flop, step code, overrun flag, instruction count.
// Optional single-step PAUSE state enabled by defining SEQ_COUNTER_CTRL_STEP_EN.
module seq_counter_ctrl #(
  parameter int SC_WIDTH   = 4,
  parameter int MAX_STEP   = 15,
  parameter int ICNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  sc_clr,
  input  logic                  ovf_clr,
`ifdef SEQ_COUNTER_CTRL_STEP_EN
  input  logic                  step_mode,
  input  logic                  step_req,
`endif
  output logic [SC_WIDTH-1:0]   sc_code,
  output logic                  running,
  output logic                  sc_ovf,
  output logic [ICNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [SC_WIDTH-1:0] LP_MAX = SC_WIDTH'(MAX_STEP);
  localparam logic [SC_WIDTH-1:0] LP_ONE = SC_WIDTH'(1);
  localparam logic [ICNT_WIDTH-1:0] LP_IONE = ICNT_WIDTH'(1);

  state_t                r_state;
  logic [SC_WIDTH-1:0]   r_sc;
  logic                  r_ovf;
  logic [ICNT_WIDTH-1:0] r_icnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HALT;
      r_sc    <= '0;
      r_ovf   <= 1'b0;
      r_icnt  <= '0;
    end else begin
      // A set from overrun below overrides this clear on the same edge.
      if (ovf_clr) r_ovf <= 1'b0;
      case (r_state)
        S_HALT: begin
          r_sc <= '0;
          if (start && !halt) r_state <= S_RUN;
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALT;
            r_sc    <= '0;
          end else if (sc_clr) begin
            r_sc   <= '0;
            r_icnt <= r_icnt + LP_IONE;
`ifdef SEQ_COUNTER_CTRL_STEP_EN
            if (step_mode) r_state <= S_PAUSE;
`endif
          end else if (r_sc == LP_MAX) begin
            r_ovf   <= 1'b1;
            r_sc    <= '0;
            r_state <= S_HALT;
          end else begin
            r_sc <= r_sc + LP_ONE;
          end
        end
`ifdef SEQ_COUNTER_CTRL_STEP_EN
        S_PAUSE: begin
          r_sc <= '0;
          if (halt) r_state <= S_HALT;
          else if (step_req || !step_mode) r_state <= S_RUN;
        end
`endif
        default: begin
          r_state <= S_HALT;
          r_sc    <= '0;
        end
      endcase
    end
  end

  assign sc_code   = r_sc;
  assign running   = (r_state != S_HALT);
  assign sc_ovf    = r_ovf;
  assign instr_cnt = r_icnt;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl with hand-computed expectations.
// Step-mode section is built only when SEQ_COUNTER_CTRL_STEP_EN is defined.
module tb_seq_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, sc_clr, ovf_clr;
  logic        step_mode, step_req;
  logic [3:0]  sc_code;
  logic        running, sc_ovf;
  logic [15:0] instr_cnt;

  int errors = 0;
  int checks = 0;

  seq_counter_ctrl #(
    .SC_WIDTH(4), .MAX_STEP(15), .ICNT_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .sc_clr    (sc_clr),
    .ovf_clr   (ovf_clr),
`ifdef SEQ_COUNTER_CTRL_STEP_EN
    .step_mode (step_mode),
    .step_req  (step_req),
`endif
    .sc_code   (sc_code),
    .running   (running),
    .sc_ovf    (sc_ovf),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; sc_clr = 1'b0;
    ovf_clr = 1'b0; step_mode = 1'b0; step_req = 1'b0;
    #2;
    chk("rst_sc", 32'(sc_code), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_ovf", 32'(sc_ovf), 0);
    chk("rst_icnt", 32'(instr_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("halt_idle_run", 32'(running), 0);

    start = 1'b1; step(); start = 1'b0;
    chk("start_run", 32'(running), 1);
    chk("start_t0", 32'(sc_code), 0);
    steps(3);
    chk("count3", 32'(sc_code), 3);
    sc_clr = 1'b1; step(); sc_clr = 1'b0;
    chk("clr_sc", 32'(sc_code), 0);
    chk("clr_icnt", 32'(instr_cnt), 1);
    chk("clr_run", 32'(running), 1);
    halt = 1'b1; step(); halt = 1'b0;
    chk("halt_run", 32'(running), 0);
    chk("halt_sc", 32'(sc_code), 0);

    sc_clr = 1'b1; step(); sc_clr = 1'b0;
    chk("halt_clr_ign", 32'(instr_cnt), 1);

    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    chk("sh_run", 32'(running), 0);
    chk("sh_sc", 32'(sc_code), 0);

    start = 1'b1; step(); start = 1'b0;
    steps(5);
    chk("count5", 32'(sc_code), 5);
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_run", 32'(sc_code), 6);
    steps(9);
    chk("max15", 32'(sc_code), 15);
    chk("max15_ovf", 32'(sc_ovf), 0);
    step();
    chk("ovr_ovf", 32'(sc_ovf), 1);
    chk("ovr_sc", 32'(sc_code), 0);
    chk("ovr_run", 32'(running), 0);

    start = 1'b1; step(); start = 1'b0;
    chk("ovf_start_run", 32'(running), 1);
    chk("ovf_sticky", 32'(sc_ovf), 1);
    steps(2);
    chk("code2", 32'(sc_code), 2);
    halt = 1'b1; sc_clr = 1'b1; step(); halt = 1'b0; sc_clr = 1'b0;
    chk("hc_run", 32'(running), 0);
    chk("hc_sc", 32'(sc_code), 0);
    chk("hc_icnt", 32'(instr_cnt), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(sc_ovf), 0);

    start = 1'b1; step(); start = 1'b0;
    steps(15);
    chk("max15_b", 32'(sc_code), 15);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("set_wins", 32'(sc_ovf), 1);
    chk("set_wins_run", 32'(running), 0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    sc_clr = 1'b1; steps(6); sc_clr = 1'b0;
    steps(5);
    chk("pre_rst_sc", 32'(sc_code), 5);
    chk("pre_rst_icnt", 32'(instr_cnt), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sc", 32'(sc_code), 0);
    chk("arst_run", 32'(running), 0);
    chk("arst_icnt", 32'(instr_cnt), 0);
    chk("arst_ovf", 32'(sc_ovf), 0);
    step();
    rst_n = 1'b1;
    step();

`ifdef SEQ_COUNTER_CTRL_STEP_EN
    step_mode = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    steps(4);
    chk("sm_code4", 32'(sc_code), 4);
    sc_clr = 1'b1; step(); sc_clr = 1'b0;
    chk("pause_icnt", 32'(instr_cnt), 1);
    for (int i = 0; i < 10; i++) begin
      chk("pause_sc", 32'(sc_code), 0);
      chk("pause_run", 32'(running), 1);
      step();
    end
    step_req = 1'b1; step(); step_req = 1'b0;
    chk("sreq_sc", 32'(sc_code), 0);
    steps(2);
    chk("sreq_cnt2", 32'(sc_code), 2);
    sc_clr = 1'b1; step(); sc_clr = 1'b0;
    chk("pause2_icnt", 32'(instr_cnt), 2);
    steps(2);
    chk("pause2_sc", 32'(sc_code), 0);
    step_mode = 1'b0; step();
    step();
    chk("resume_sc", 32'(sc_code), 1);
    halt = 1'b1; step(); halt = 1'b0;
    chk("sm_halt", 32'(running), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
- Sequence-counter (SC) controller for the basic computer's timing chain.
- Produces the 4-bit step code that the downstream 4-to-16 decoder turns into one-hot timing signals T0..T15.
- Owns the start/halt run flip-flop, clear-on-instruction-end, terminal-count overrun detection and a retired-instruction counter.

Parameters:
- SC_WIDTH, 4, width of the step code; the decoder expects 4.
- MAX_STEP, 15, highest legal step. Reaching it without a clear is an overrun. Legal range 1 to 2^SC_WIDTH-1.
- ICNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level/pulse; leave HALT and begin fetch at T0.
- halt  in  1  HLT executed; stop at this edge.
- sc_clr  in  1  end of instruction; SC returns to 0 next edge.
- ovf_clr  in  1  clears the sticky overrun flag.
- sc_code  out  SC_WIDTH  step code to the decoder.
- running  out  1  run flip-flop S; decoder outputs are meaningful only when high.
- sc_ovf  out  1  sticky: SC hit MAX_STEP with no sc_clr.
- instr_cnt  out  ICNT_WIDTH  count of sc_clr events accepted while running; wraps.

Behaviour:
- Reset (rst_n low, asynchronous): state HALT, sc_code=0, running=0, sc_ovf=0, instr_cnt=0. Release is synchronous to clk in effect: first state change is on the first rising edge with rst_n high.
- States: HALT, RUN (PAUSE only with the optional feature). running=1 exactly when state is RUN or PAUSE.
- HALT:
  - sc_code held at 0; sc_clr is ignored.
  - start=1 and halt=0 -> RUN next edge, sc_code stays 0. T0 is therefore the first cycle with running=1.
  - start=1 and halt=1 together -> stay in HALT; halt wins.
- RUN, priority per edge is halt > sc_clr > increment:
  - halt=1 -> HALT, sc_code<=0. sc_clr on the same edge is not counted.
  - else sc_clr=1 -> sc_code<=0, instr_cnt<=instr_cnt+1, modulo 2^ICNT_WIDTH.
  - else sc_code==MAX_STEP -> overrun: sc_ovf<=1, sc_code<=0, state<=HALT.
  - else sc_code<=sc_code+1.
- Latency: every control input takes effect on the next rising edge; no combinational path from inputs to outputs.
- start while RUN: ignored.
- sc_ovf:
  - Set only by overrun; cleared only by ovf_clr=1 or reset.
  - If set and clear occur on the same edge, set wins.
  - sc_ovf=1 does not block a later start.
- Every increment stays within SC_WIDTH bits; sc_code never exceeds MAX_STEP.

Optional Feature:
- Macro: SEQ_COUNTER_CTRL_STEP_EN
- When defined, the block gains two inputs:
  - step_mode  in  1
  - step_req  in  1
- Behaviour with the macro defined:
  - In RUN with step_mode=1, an accepted sc_clr (instruction end) moves the block to PAUSE instead of continuing. It still returns sc_code to 0 and counts the instruction.
  - PAUSE holds sc_code=0 with running=1.
  - step_req=1 in PAUSE -> RUN next edge; exactly one more instruction executes, then PAUSE again.
  - halt=1 in PAUSE -> HALT.
  - step_mode dropping to 0 while in PAUSE -> RUN next edge.
- Without the macro: ports and the PAUSE state are absent; behaviour is exactly as above.

Test Plan:
- Reset, then start pulse -> next edge running=1, sc_code=0. Following edges give 1,2,3; sc_clr at sc_code=3 -> sc_code=0, instr_cnt=1.
- start and halt asserted together while in HALT -> running stays 0, sc_code stays 0.
- Run with sc_clr never asserted, MAX_STEP=15 -> sc_code reaches 15, then next edge sc_ovf=1, sc_code=0, running=0. Pulse ovf_clr -> sc_ovf=0.
- halt and sc_clr together at sc_code=2 -> running=0, sc_code=0, instr_cnt unchanged.
- rst_n dropped mid-instruction at sc_code=5 with instr_cnt=7 -> all outputs 0 immediately, without waiting for a clock edge.
- With SEQ_COUNTER_CTRL_STEP_EN and step_mode=1, sc_clr at sc_code=4 -> PAUSE with sc_code=0 held for 10 cycles. step_req -> sc_code counts 1,2,... until the next sc_clr, then PAUSE again; instr_cnt incremented by 2 in total.
